// File: rtl/sr_pkg.sv
// Shared types, limits and next-state rule for the SR flip-flop bank.
package sr_pkg;

    // Policy applied when set and reset are both requested in the same enabled cycle
    typedef enum logic [1:0] {
        SR_RST_DOM = 2'd0,
        SR_SET_DOM = 2'd1,
        SR_HOLD    = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    localparam int unsigned SR_N_MIN     = 1;
    localparam int unsigned SR_N_MAX     = 64;
    localparam int unsigned SR_CNT_W_MIN = 2;
    localparam int unsigned SR_CNT_W_MAX = 16;

    // Next value of one channel given its current state and its set/reset requests
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input sr_mode_e mode);
        logic nxt;
        nxt = q;
        unique case ({s, r})
            2'b00: nxt = q;
            2'b10: nxt = 1'b1;
            2'b01: nxt = 1'b0;
            2'b11: begin
                unique case (mode)
                    SR_RST_DOM: nxt = 1'b0;
                    SR_SET_DOM: nxt = 1'b1;
                    SR_HOLD:    nxt = q;
                    SR_TOGGLE:  nxt = ~q;
                    default:    nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: the state flop, its next-state logic and registered edge pulses.
module sr_cell
    import sr_pkg::*;
#(
    parameter sr_mode_e MODE = SR_RST_DOM
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_q;
    logic q_d;
    logic rise_q;
    logic fall_q;

    // Requests only take effect while the bank is enabled; otherwise the channel holds
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = sr_next(q_q, s, r, MODE);
        end
    end

    // State flop plus pulses marking a change of state on this edge; reset clears all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rise_q <= ~q_q & q_d;
            fall_q <= q_q & ~q_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of N independent SR flip-flops sharing one enable, with conflict detection.
// Define SR_FLOP_BANK_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module sr_flop_bank
    import sr_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     s,
    input  logic [N-1:0]     r,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qn,
    output logic [N-1:0]     rise,
    output logic [N-1:0]     fall,
`ifdef SR_FLOP_BANK_CONFLICT_CNT_EN
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    output logic             conflict
);

    // Out-of-range parameters are rejected while elaborating
    if (MODE > 3) begin : g_bad_mode
        $error("sr_flop_bank: MODE must be 0..3");
    end
    if (N < SR_N_MIN || N > SR_N_MAX) begin : g_bad_n
        $error("sr_flop_bank: N must be 1..64");
    end
    if (CNT_W < SR_CNT_W_MIN || CNT_W > SR_CNT_W_MAX) begin : g_bad_cnt_w
        $error("sr_flop_bank: CNT_W must be 2..16");
    end

    localparam logic [1:0] MODE_BITS = MODE[1:0];
    localparam sr_mode_e   CELL_MODE = sr_mode_e'(MODE_BITS);

    logic conflict_q;
    logic conflict_d;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sr_cell #(
            .MODE (CELL_MODE)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .s    (s[i]),
            .r    (r[i]),
            .q    (q[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign qn = ~q;

    // Any enabled channel asking for set and reset at once counts as a conflict
    always_comb begin
        conflict_d = en & (|(s & r));
    end

    // Conflict flag is registered so it lines up with the q update it describes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict = conflict_q;

`ifdef SR_FLOP_BANK_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // One increment per flagged cycle, sticking at full scale
    always_comb begin
        cnt_d = cnt_q;
        if (conflict_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter only clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule
